// File: rtl/axi4lite_master_bridge.sv
// Single-outstanding AXI4-Lite initiator: turns one-beat simple-bus commands into AXI4-Lite reads/writes.
// Optional response-wait abort (debug only) is compiled in with `define AXI4LITE_MASTER_TIMEOUT_EN.
module axi4lite_master_bridge #(
    parameter int C_M_AXI_ADDR_WIDTH = 6,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            cmdWr,
    input  logic                            cmdRd,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmdAddr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmdWrData,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmdWrStrb,
    output logic                            cmdReady,
    output logic                            rspValid,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rspRdData,
    output logic [1:0]                      rspResp,
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
    output logic                            timeoutFlag,
`endif
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t                          state;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]               wstrb_q;
    logic                            aw_done;
    logic                            w_done;
    logic                            aw_hs;
    logic                            w_hs;

    assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID & M_AXI_WREADY;

    // One shared address latch serves both AW and AR since only one transaction is ever in flight.
    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;

    // NOTE: cmdReady is combinational so it is low during reset yet high the very first cycle after it.
    assign cmdReady = (state == IDLE) & ~M_AXI_ARESET;

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             txn_done;

    assign txn_done = ((state == WR_RESP) & M_AXI_BVALID) | ((state == RD_DATA) & M_AXI_RVALID);
`endif

    // NOTE: every register here uses <=, so all branches read the pre-edge values regardless of order.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            // NOTE: the small data/address latches are reset too, so a bus snoop never sees stale X values.
            state         <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rspValid      <= 1'b0;
            rspRdData     <= '0;
            rspResp       <= 2'b00;
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
            tmo_cnt       <= '0;
            timeoutFlag   <= 1'b0;
`endif
        end else begin
            rspValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmdRd) begin
                        addr_q        <= cmdAddr;
                        M_AXI_ARVALID <= 1'b1;
                        state         <= RD_ADDR;
                    end else if (cmdWr) begin
                        addr_q        <= cmdAddr;
                        wdata_q       <= cmdWrData;
                        wstrb_q       <= cmdWrStrb;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        state         <= WR_ADDR_DATA;
                    end
                end
                WR_ADDR_DATA: begin
                    if (aw_hs) begin
                        M_AXI_AWVALID <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        M_AXI_WVALID <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        rspResp      <= M_AXI_BRESP;
                        rspValid     <= 1'b1;
                        state        <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        rspRdData    <= M_AXI_RDATA;
                        rspResp      <= M_AXI_RRESP;
                        rspValid     <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
            // Placed after the case so an abort overrides whatever the state branch scheduled.
            if ((state == IDLE) || txn_done) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state         <= IDLE;
                M_AXI_AWVALID <= 1'b0;
                M_AXI_WVALID  <= 1'b0;
                M_AXI_BREADY  <= 1'b0;
                M_AXI_ARVALID <= 1'b0;
                M_AXI_RREADY  <= 1'b0;
                rspValid      <= 1'b1;
                rspResp       <= 2'b11;
                timeoutFlag   <= 1'b1;
                tmo_cnt       <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
// Bench for axi4lite_master_bridge: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a channel-level reference model.
module tb_axi4lite_master_bridge;

    localparam int AW  = 6;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_wr, cmd_rd;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          cmd_ready, rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          timeout_flag;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi4lite_master_bridge #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESET (rst),
        .cmdWr        (cmd_wr),
        .cmdRd        (cmd_rd),
        .cmdAddr      (cmd_addr),
        .cmdWrData    (cmd_wdata),
        .cmdWrStrb    (cmd_strb),
        .cmdReady     (cmd_ready),
        .rspValid     (rsp_valid),
        .rspRdData    (rsp_rdata),
        .rspResp      (rsp_resp),
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
        .timeoutFlag  (timeout_flag),
`endif
        .M_AXI_AWADDR (awaddr),
        .M_AXI_AWPROT (awprot),
        .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA  (wdata),
        .M_AXI_WSTRB  (wstrb),
        .M_AXI_WVALID (wvalid),
        .M_AXI_WREADY (wready),
        .M_AXI_BRESP  (bresp),
        .M_AXI_BVALID (bvalid),
        .M_AXI_BREADY (bready),
        .M_AXI_ARADDR (araddr),
        .M_AXI_ARPROT (arprot),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA  (rdata),
        .M_AXI_RRESP  (rresp),
        .M_AXI_RVALID (rvalid),
        .M_AXI_RREADY (rready)
    );

`ifndef AXI4LITE_MASTER_TIMEOUT_EN
    assign timeout_flag = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Reference model: tracks which channels are open for the one transaction in flight.
    logic          m_busy, m_rd, m_aw, m_w, m_b, m_ar, m_r, m_rsp_v, m_tflag;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_rd_data;
    logic [SW-1:0] m_strb;
    logic [1:0]    m_resp;
    int            m_wait;

    always @(posedge clk) begin : model
        logic aw_n, w_n, fin;
        fin = 1'b0;
        if (rst) begin
            {m_busy, m_rd, m_aw, m_w, m_b, m_ar, m_r, m_rsp_v, m_tflag} <= '0;
            m_addr <= '0; m_data <= '0; m_strb <= '0; m_rd_data <= '0; m_resp <= '0;
            m_wait <= 0;
        end else begin
            m_rsp_v <= 1'b0;
            if (!m_busy) begin
                if (cmd_rd) begin
                    m_busy <= 1'b1; m_rd <= 1'b1; m_addr <= cmd_addr; m_ar <= 1'b1;
                end else if (cmd_wr) begin
                    m_busy <= 1'b1; m_rd <= 1'b0; m_addr <= cmd_addr;
                    m_data <= cmd_wdata; m_strb <= cmd_strb; m_aw <= 1'b1; m_w <= 1'b1;
                end
            end else if (m_rd) begin
                if (m_ar) begin
                    if (arready) begin m_ar <= 1'b0; m_r <= 1'b1; end
                end else if (rvalid) begin
                    fin = 1'b1;
                    m_r <= 1'b0; m_busy <= 1'b0; m_rd_data <= rdata; m_resp <= rresp; m_rsp_v <= 1'b1;
                end
            end else if (m_b) begin
                if (bvalid) begin
                    fin = 1'b1;
                    m_b <= 1'b0; m_busy <= 1'b0; m_resp <= bresp; m_rsp_v <= 1'b1;
                end
            end else begin
                aw_n = m_aw && !awready;
                w_n  = m_w && !wready;
                m_aw <= aw_n;
                m_w  <= w_n;
                if (!aw_n && !w_n) m_b <= 1'b1;
            end
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
            if (!m_busy) begin
                m_wait <= 0;
            end else if (!fin) begin
                if (m_wait == TMO - 1) begin
                    {m_busy, m_aw, m_w, m_b, m_ar, m_r} <= '0;
                    m_rsp_v <= 1'b1; m_resp <= 2'b11; m_tflag <= 1'b1; m_wait <= 0;
                end else begin
                    m_wait <= m_wait + 1;
                end
            end
`endif
        end
    end

    // Compare process: every DUT output against the model, mid-cycle.
    always @(negedge clk) begin
        check("cmdReady",  cmd_ready, !m_busy && !rst);
        check("rspValid",  rsp_valid, m_rsp_v);
        check("rspResp",   rsp_resp, m_resp);
        check("rspRdData", rsp_rdata, m_rd_data);
        check("AWVALID",   awvalid, m_aw);
        check("WVALID",    wvalid, m_w);
        check("BREADY",    bready, m_b);
        check("ARVALID",   arvalid, m_ar);
        check("RREADY",    rready, m_r);
        check("AWADDR",    awaddr, m_addr);
        check("ARADDR",    araddr, m_addr);
        check("WDATA",     wdata, m_data);
        check("WSTRB",     wstrb, m_strb);
        check("PROT",      {awprot, arprot}, 6'd0);
        check("timeoutFlag", timeout_flag, m_tflag);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        cmd_wr = 0; cmd_rd = 0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = '0; rresp = '0; rdata = '0;
    endtask

    int p_rdy;

    initial begin
        quiet();
        rst = 1'b1;
        tick(); tick();
        check("rst_cmdReady", cmd_ready, 1'b0);
        check("rst_rspRdData", rsp_rdata, '0);
        rst = 1'b0;
        #1 check("post_rst_cmdReady", cmd_ready, 1'b1);

        // 1: write with all readies high -> rspValid at T3.
        cmd_wr = 1; cmd_addr = 6'h08; cmd_wdata = 32'hDEADBEEF; cmd_strb = 4'hF;
        awready = 1; wready = 1; arready = 1;
        tick(); cmd_wr = 0;
        check("t1_awvalid", awvalid, 1'b1);
        check("t1_wvalid", wvalid, 1'b1);
        check("t1_awaddr", awaddr, 6'h08);
        check("t1_wdata", wdata, 32'hDEADBEEF);
        tick();
        check("t1_aw_drop", awvalid, 1'b0);
        check("t1_bready", bready, 1'b1);
        bvalid = 1; bresp = 2'b00;
        tick(); bvalid = 0;
        check("t1_rspvalid", rsp_valid, 1'b1);
        check("t1_rspresp", rsp_resp, 2'b00);
        check("t1_backtoback_ready", cmd_ready, 1'b1);
        tick();
        check("t1_single_pulse", rsp_valid, 1'b0);

        // 2: read with three R wait cycles.
        cmd_rd = 1; cmd_addr = 6'h0C;
        tick(); cmd_rd = 0;
        check("t2_arvalid", arvalid, 1'b1);
        check("t2_araddr", araddr, 6'h0C);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_rready_wait", rready, 1'b1);
            check("t2_no_rsp", rsp_valid, 1'b0);
        end
        rvalid = 1; rdata = 32'h12345678; rresp = 2'b00;
        tick(); rvalid = 0;
        check("t2_rspvalid", rsp_valid, 1'b1);
        check("t2_rdata", rsp_rdata, 32'h12345678);
        check("t2_rresp", rsp_resp, 2'b00);
        tick();
        check("t2_single_pulse", rsp_valid, 1'b0);

        // 3: WREADY four cycles ahead of AWREADY.
        awready = 0; wready = 1;
        cmd_wr = 1; cmd_addr = 6'h10; cmd_wdata = 32'hA5A50F0F; cmd_strb = 4'h3;
        tick(); cmd_wr = 0;
        check("t3_both_valid", {awvalid, wvalid}, 2'b11);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_w_dropped", wvalid, 1'b0);
            check("t3_aw_held", awvalid, 1'b1);
            check("t3_no_bready", bready, 1'b0);
        end
        awready = 1;
        tick();
        check("t3_aw_drop", awvalid, 1'b0);
        check("t3_bready", bready, 1'b1);
        bvalid = 1; bresp = 2'b10;
        tick(); bvalid = 0;
        check("t3_rspvalid", rsp_valid, 1'b1);
        check("t3_bresp", rsp_resp, 2'b10);
        check("t3_rdata_held", rsp_rdata, 32'h12345678);
        check("t3_one_bphase", bready, 1'b0);
        tick();
        check("t3_single_pulse", rsp_valid, 1'b0);

        // 4: simultaneous read and write -> read wins.
        cmd_rd = 1; cmd_wr = 1; cmd_addr = 6'h04; cmd_wdata = 32'h11112222; cmd_strb = 4'hF;
        tick(); cmd_rd = 0; cmd_wr = 0;
        check("t4_arvalid", arvalid, 1'b1);
        check("t4_no_aw", {awvalid, wvalid}, 2'b00);
        tick();
        rvalid = 1; rdata = 32'hCAFEF00D; rresp = 2'b01;
        tick(); rvalid = 0;
        check("t4_rspvalid", rsp_valid, 1'b1);
        check("t4_rdata", rsp_rdata, 32'hCAFEF00D);
        check("t4_rresp", rsp_resp, 2'b01);
        check("t4_still_no_aw", awvalid, 1'b0);

        // 5: reset while waiting for B.
        cmd_wr = 1; cmd_addr = 6'h20; cmd_wdata = 32'h0BADF00D; cmd_strb = 4'hC;
        tick(); cmd_wr = 0;
        tick();
        check("t5_bready", bready, 1'b1);
        rst = 1; bvalid = 0;
        tick();
        check("t5_rst_outputs", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'd0);
        check("t5_rst_rsp", {rsp_rdata, rsp_resp}, '0);
        check("t5_rst_latches", {awaddr, wdata, wstrb}, '0);
        check("t5_rst_ready", cmd_ready, 1'b0);
        rst = 0;
        #1 check("t5_ready_after", cmd_ready, 1'b1);
        tick();
        check("t5_no_rsp", rsp_valid, 1'b0);

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
        // 6: read with ARREADY stuck low -> DECERR abort after TMO busy cycles.
        arready = 0;
        cmd_rd = 1; cmd_addr = 6'h2C;
        tick(); cmd_rd = 0;
        for (int k = 1; k <= TMO; k++) begin
            check("t6_arvalid_held", arvalid, 1'b1);
            check("t6_no_rsp", rsp_valid, 1'b0);
            tick();
        end
        check("t6_arvalid_drop", arvalid, 1'b0);
        check("t6_rspvalid", rsp_valid, 1'b1);
        check("t6_decerr", rsp_resp, 2'b11);
        check("t6_rdata_kept", rsp_rdata, '0);
        check("t6_flag", timeout_flag, 1'b1);
        tick(); tick();
        check("t6_flag_sticky", timeout_flag, 1'b1);
        check("t6_idle", cmd_ready, 1'b1);
`endif

        // Randomized traffic: slave behaviour follows the model's open channels.
        quiet();
        p_rdy = 50;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 400 == 0) begin
                case ($urandom_range(0, 2))
                    0: p_rdy = 90;
                    1: p_rdy = 50;
                    default: p_rdy = 8;
                endcase
            end
            rst       = ($urandom_range(0, 299) == 0);
            cmd_wr    = ($urandom_range(0, 3) == 0);
            cmd_rd    = ($urandom_range(0, 3) == 0);
            cmd_addr  = AW'($urandom);
            cmd_wdata = $urandom;
            cmd_strb  = SW'($urandom);
            awready   = ($urandom_range(0, 99) < p_rdy);
            wready    = ($urandom_range(0, 99) < p_rdy);
            arready   = ($urandom_range(0, 99) < p_rdy);
            bvalid    = m_b && ($urandom_range(0, 99) < p_rdy);
            rvalid    = m_r && ($urandom_range(0, 99) < p_rdy);
            bresp     = 2'($urandom);
            rresp     = 2'($urandom);
            rdata     = $urandom;
            tick();
        end

        quiet();
        rst = 1;
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
